// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead receive FIFO.
// The serial line is synchronized and then framed by a small FSM. The FSM
// counts clock cycles from the start-bit edge and samples near the middle of
// each bit. Completed bytes are pushed into a power-of-two FIFO.
// Optional build macro: UART_RX_MAJORITY_EN. When it is defined, each bit
// decision is the 2-of-3 vote of three adjacent samples instead of a single
// mid-bit sample.

module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  output logic [7:0]                    data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_error,
  output logic                          overflow
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME + 1);
  localparam int AW               = $clog2(FIFO_DEPTH);

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample one cycle after mid-bit, so the start decision
  // moves one cycle later. The data and stop grid inherits that shift.
  localparam int START_DECIDE = SAMPLE_TIME + 1;
`else
  localparam int START_DECIDE = SAMPLE_TIME;
`endif
  // Data and stop decisions fall one full bit period after the previous
  // decision. The counter restarts at 0 on the cycle after each decision.
  localparam int BIT_DECIDE = SYMBOL_EDGE_TIME - 1;

  localparam logic [CW-1:0] START_DECIDE_C = CW'(START_DECIDE);
  localparam logic [CW-1:0] BIT_DECIDE_C   = CW'(BIT_DECIDE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;

  // Two-flop synchronizer. It resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], serial_in};
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------------
  // Bit sampling
  // ---------------------------------------------------------------------
  logic sample_bit;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // The last two synced samples. At a decision cycle these are the samples
  // taken one and two cycles before the current one.
  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= {hist_q[0], rx_s};
  end

  assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  // ---------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push;
  logic          framing_error_q, framing_error_d;

  // FSM state, cycle counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shift_q         <= shift_d;
      framing_error_q <= framing_error_d;
    end
  end

  // Next state. The counter is cleared on every state entry.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + 1'b1;
    idx_d           = idx_q;
    shift_d         = shift_q;
    push            = 1'b0;
    framing_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == START_DECIDE_C) begin
          cnt_d = '0;
          if (sample_bit) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_DECIDE_C) begin
          cnt_d          = '0;
          shift_d[idx_q] = sample_bit;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_DECIDE_C) begin
          cnt_d = '0;
          if (sample_bit) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // A break holds the line low. Ignore it until the line returns high,
        // so that the break does not produce 0x00 bytes.
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        empty, full, pop, push_ok, overflow_q, overflow_d;

  assign empty      = (wr_q == rd_q);
  assign full       = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign pop        = !empty && data_out_ready;
  // A pop in the same cycle frees the head slot, so a push into a full
  // FIFO is accepted.
  assign push_ok    = push && (!full || pop);
  assign overflow_d = push && full && !pop;

  // Storage write. The byte is taken straight from the completed shift
  // register.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= shift_q;
  end

  // Pointers and the registered overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_q + (AW+1)'(push_ok);
      rd_q       <= rd_q + (AW+1)'(pop);
      overflow_q <= overflow_d;
    end
  end

  assign data_out_valid = !empty;
  // The head is forced to zero while empty, so that reset shows a clean 0x00.
  assign data_out       = empty ? 8'h00 : mem[rd_q[AW-1:0]];
  assign fifo_count     = wr_q - rd_q;
  assign framing_error  = framing_error_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo. The fast instance runs at 5 cycles
// per bit. The slow instance runs at 50 cycles per bit and is used for the
// mid-bit glitch case.
module tb_uart_rx_fifo;
  localparam int SET  = 5;
  localparam int SET2 = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial;
  logic       ready, ready2;
  logic [7:0] dout, dout2;
  logic       valid, valid2;
  logic [3:0] cnt, cnt2;
  logic       fe, fe2, ov, ov2;

  always #10 clk = ~clk;

  uart_rx_fifo #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(10_000_000), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .serial_in(serial), .data_out(dout), .data_out_valid(valid),
    .data_out_ready(ready), .fifo_count(cnt), .framing_error(fe), .overflow(ov));

  uart_rx_fifo #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(1_000_000), .FIFO_DEPTH(8)) dut_slow (
    .clk(clk), .rst(rst), .serial_in(serial), .data_out(dout2), .data_out_valid(valid2),
    .data_out_ready(ready2), .fifo_count(cnt2), .framing_error(fe2), .overflow(ov2));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  logic [7:0] popped[$];
  logic [7:0] popped2[$];
  int fe_cycles, ov_cycles, valid_cycles, first_valid_cyc, slow_flag_cycles;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid && ready) popped.push_back(dout);
    if (valid) begin
      valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (fe) fe_cycles++;
    if (ov) ov_cycles++;
    if (valid2 && ready2) popped2.push_back(dout2);
    if (fe2 || ov2) slow_flag_cycles++;
  end

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] exp_count;
    logic [7:0] exp_head;
    logic       exp_ov;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic clear_mon();
    popped.delete();
    fe_cycles = 0;
    ov_cycles = 0;
    valid_cycles = 0;
    first_valid_cyc = -1;
  endtask

  task automatic idle(input int n);
    serial = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame, one line cycle at a time. If glitch >= 0, the line is
  // inverted at that line-cycle index.
  task automatic send(input logic [7:0] b, input logic stop, input int set, input int glitch);
    int   bi;
    logic v;
    for (int i = 0; i < 10 * set; i++) begin
      bi = i / set;
      if (bi == 0)      v = 1'b0;
      else if (bi == 9) v = stop;
      else              v = b[bi-1];
      if (i == glitch) v = ~v;
      serial = v;
      @(posedge clk);
      #1;
    end
    serial = 1'b1;
  endtask

  function automatic logic [31:0] q_at(input logic [7:0] q[$], input int i);
    if (i < q.size()) return 32'(q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    logic [7:0] drain_exp[8];
    logic [7:0] slow_exp;
    logic [7:0] bf;
    int         start_cyc, ov_before, lat;
    logic       v;

    vecs[0] = '{8'h30, 4'd1, 8'h30, 1'b0};
    vecs[1] = '{8'h31, 4'd2, 8'h30, 1'b0};
    vecs[2] = '{8'h32, 4'd3, 8'h30, 1'b0};
    vecs[3] = '{8'h33, 4'd4, 8'h30, 1'b0};
    vecs[4] = '{8'h34, 4'd5, 8'h30, 1'b0};
    vecs[5] = '{8'h35, 4'd6, 8'h30, 1'b0};
    vecs[6] = '{8'h36, 4'd7, 8'h30, 1'b0};
    vecs[7] = '{8'h37, 4'd8, 8'h30, 1'b0};
    vecs[8] = '{8'h38, 4'd8, 8'h30, 1'b1};
    drain_exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h39};

    rst = 1'b1; serial = 1'b1; ready = 1'b0; ready2 = 1'b1;
    clear_mon();
    slow_flag_cycles = 0;
    idle(4);
    check("reset_valid", 32'(valid), 0);
    check("reset_count", 32'(cnt), 0);
    check("reset_fe", 32'(fe), 0);
    check("reset_ov", 32'(ov), 0);
    check("reset_dout", 32'(dout), 0);
    rst = 1'b0;
    idle(5);

    // Single byte, consumer always ready.
    clear_mon();
    ready = 1'b1;
    start_cyc = cyc;
    send(8'h61, 1'b1, SET, -1);
    idle(8);
    lat = first_valid_cyc - start_cyc;
    check("single_npop", popped.size(), 1);
    check("single_byte", q_at(popped, 0), 32'h61);
    check("single_valid_cycles", valid_cycles, 1);
    check("single_latency_in_range", 32'((first_valid_cyc >= 0) && (lat >= 50) && (lat <= 54)), 1);
    check("single_no_fe", fe_cycles, 0);
    check("single_no_ov", ov_cycles, 0);

    // Four back-to-back frames, consumer stalled, then drained.
    ready = 1'b0;
    clear_mon();
    send(8'h61, 1'b1, SET, -1);
    send(8'h62, 1'b1, SET, -1);
    send(8'h63, 1'b1, SET, -1);
    send(8'h64, 1'b1, SET, -1);
    idle(6);
    check("four_count", 32'(cnt), 4);
    check("four_head", 32'(dout), 32'h61);
    ready = 1'b1;
    idle(8);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) check($sformatf("four_pop%0d", i), q_at(popped, i), 32'h61 + i);
    check("four_npop", popped.size(), 4);
    check("four_drained_count", 32'(cnt), 0);
    check("four_drained_valid", 32'(valid), 0);

    // Fill to full and one past it, from the vector table.
    clear_mon();
    for (int i = 0; i < 9; i++) begin
      ov_before = ov_cycles;
      send(vecs[i].data, 1'b1, SET, -1);
      idle(4);
      check($sformatf("fill%0d_count", i), 32'(cnt), 32'(vecs[i].exp_count));
      check($sformatf("fill%0d_head", i), 32'(dout), 32'(vecs[i].exp_head));
      check($sformatf("fill%0d_ovpulse", i), ov_cycles - ov_before, 32'(vecs[i].exp_ov));
    end

    // Full FIFO: push and pop in the same cycle. Both are accepted.
    ov_before = ov_cycles;
    send(8'h39, 1'b1, SET, -1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    idle(4);
    check("fullpp_count", 32'(cnt), 8);
    check("fullpp_no_ov", ov_cycles - ov_before, 0);
    check("fullpp_head", 32'(dout), 32'h31);
    popped.delete();
    ready = 1'b1;
    idle(12);
    ready = 1'b0;
    for (int i = 0; i < 8; i++) check($sformatf("drain%0d", i), q_at(popped, i), 32'(drain_exp[i]));
    check("drain_count", 32'(cnt), 0);

    // Framing error, then a long break, then a good frame.
    clear_mon();
    ready = 1'b1;
    send(8'h55, 1'b0, SET, -1);
    serial = 1'b0;
    repeat (3 * SET) begin
      @(posedge clk);
      #1;
    end
    idle(10);
    send(8'h0d, 1'b1, SET, -1);
    idle(8);
    check("break_fe_cycles", fe_cycles, 1);
    check("break_npop", popped.size(), 1);
    check("break_byte", q_at(popped, 0), 32'h0d);
    check("break_no_ov", ov_cycles, 0);

    // One-cycle low glitch on an idle line.
    clear_mon();
    serial = 1'b0;
    @(posedge clk);
    #1;
    idle(20);
    check("glitch_no_valid", valid_cycles, 0);
    check("glitch_no_fe", fe_cycles, 0);
    send(8'h2a, 1'b1, SET, -1);
    idle(8);
    check("glitch_next_npop", popped.size(), 1);
    check("glitch_next_byte", q_at(popped, 0), 32'h2a);

    // Reset during bit 4 of a frame while the FIFO holds a byte.
    clear_mon();
    ready = 1'b0;
    send(8'h11, 1'b1, SET, -1);
    idle(4);
    check("prereset_count", 32'(cnt), 1);
    bf = 8'hF5;
    for (int i = 0; i < 10 * SET; i++) begin
      if (i < SET)           v = 1'b0;
      else if (i >= 9 * SET) v = 1'b1;
      else                   v = bf[i/SET - 1];
      if (i == 5 * SET) rst = 1'b1;
      serial = v;
      @(posedge clk);
      #1;
      if (rst) begin
        rst = 1'b0;
        check("midreset_valid", 32'(valid), 0);
        check("midreset_count", 32'(cnt), 0);
      end
    end
    idle(20);
    ready = 1'b1;
    send(8'h3e, 1'b1, SET, -1);
    idle(8);
    check("postreset_npop", popped.size(), 1);
    check("postreset_byte", q_at(popped, 0), 32'h3e);
    check("postreset_no_fe", fe_cycles, 0);

    // Slow instance: a one-cycle inversion at the centre of bit 3 of 0xa5.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);
    popped2.delete();
    slow_flag_cycles = 0;
`ifdef UART_RX_MAJORITY_EN
    slow_exp = 8'ha5;
`else
    slow_exp = 8'had;
`endif
    send(8'ha5, 1'b1, SET2, 4 * SET2 + 26);
    idle(80);
    check("slow_npop", popped2.size(), 1);
    check("slow_byte", q_at(popped2, 0), 32'(slow_exp));
    check("slow_no_flags", slow_flag_cycles, 0);
    check("slow_count", 32'(cnt2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

On-chip UART receiver with a receive FIFO. It sits between the `serial_in` pin of `cpu` and the memory-mapped UART data and status registers. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, idle high) from the host's serial line. Received bytes are buffered in a show-ahead FIFO, so the BIOS polling loop can fall behind by several characters without losing input.

## Interface
Parameters:
- `CLOCK_FREQ`, default 50_000_000: clk frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in baud. `SYMBOL_EDGE_TIME` = `CLOCK_FREQ/BAUD_RATE` (integer divide) must be ≥ 4.
- `FIFO_DEPTH`, default 8: number of entries. Must be a power of two, ≥ 2.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `serial_in`, input, 1: asynchronous RX line, idle high.
- `data_out`, output, 8: byte at the FIFO head.
- `data_out_valid`, output, 1: FIFO non-empty.
- `data_out_ready`, input, 1: consumer pops the head when valid && ready.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `framing_error`, output, 1: one-cycle pulse when the stop bit samples 0.
- `overflow`, output, 1: one-cycle pulse when a completed byte is dropped because the FIFO is full.

## Operation
- Input synchronizer: two flops on `serial_in`, both reset to 1. All logic uses the synced value `rx_s`.
- `SAMPLE_TIME` = `SYMBOL_EDGE_TIME/2`. A cycle counter is reloaded at every state entry.
- FSM states:
  - IDLE: on `rx_s`==0, go to START with the counter at 0.
  - START: at count `SAMPLE_TIME`, sample the line. If it reads 1 (false start), go to IDLE. If it reads 0, go to DATA, reset the counter and bit index = 0.
  - DATA: every `SYMBOL_EDGE_TIME` cycles, sample into shift register bit[index], LSB first. After bit 7, go to STOP.
  - STOP: after `SYMBOL_EDGE_TIME` cycles, sample. If it reads 1, push the byte and go to IDLE. If it reads 0, pulse `framing_error`, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This stops a break condition from producing 0x00 bytes.
- FIFO: show-ahead. `data_out` = mem[rd_ptr]. Pointers are log2(DEPTH) wide plus one wrap bit. Empty = pointers equal. Full = pointers differ only in the wrap bit.
  - Pop: when valid && ready. `data_out` is don't-care when not valid.
  - Push when full and no pop in the same cycle: the byte is dropped, `overflow` pulses, the FIFO is unchanged.
  - Push and pop in the same cycle when full: both are accepted, count is unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only. There is no bypass.
- Reset while a frame is in progress: FSM → IDLE, FIFO emptied, synchronizer set to 1. The remainder of that frame is discarded, possibly after a false start. The next complete frame is received normally.

## Timing
- Reset values:
  - `data_out_valid` 0
  - `fifo_count` 0
  - `framing_error` 0
  - `overflow` 0
  - `data_out` 0
  - FSM in IDLE
- Falling edge of the line to `rx_s` low: 2–3 cycles.
- Stop-bit sample occurs 9·`SYMBOL_EDGE_TIME` + `SAMPLE_TIME` cycles after START entry.
- `data_out_valid` rises the cycle after the stop-bit sample when the FIFO was empty.
- `framing_error` and `overflow` are asserted in the cycle after the stop-bit sample, for exactly 1 cycle.
- `fifo_count` updates the cycle after a push or pop.
- Back-to-back frames are accepted with no extra idle time: IDLE is re-entered at mid-stop-bit.

## Configuration
- Macro `UART_RX_MAJORITY_EN`:
  - Defined: every sample (start, data, stop) is the 2-of-3 majority of `rx_s` at counts `SAMPLE_TIME`-1, `SAMPLE_TIME` and `SAMPLE_TIME`+1, relative to the same bit-period grid. The decision is made at `SAMPLE_TIME`+1, so all output timing shifts by +1 cycle.
  - Not defined: single sample at `SAMPLE_TIME`. A glitch at that cycle corrupts the bit.

## Test plan
All scenarios use `CLOCK_FREQ`=50_000_000, `BAUD_RATE`=10_000_000 (5 cycles/bit) and depth 8 unless noted.
- Send 0x61 with `data_out_ready` held 1 → `data_out`=0x61 and valid for exactly 1 cycle, within 50+4 cycles of the start edge. `framing_error` and `overflow` never assert.
- Send 0x61, 0x62, 0x63, 0x64 with ready=0 → `fifo_count`=4. Raise ready → 0x61, 0x62, 0x63, 0x64 popped in order, then valid=0 and count=0.
- Send 9 bytes 0x30..0x38 with ready=0 → `overflow` pulses once, at the 9th stop bit. `fifo_count`=8. Drain yields 0x30..0x37.
- Send 0x55 with the stop bit driven 0, hold the line low for 3 bit times, then send 0x0d → one `framing_error` pulse, no 0x00 pushed, then 0x0d received.
- Drive a 1-cycle low glitch on an idle line → no byte, FSM back in IDLE. With `UART_RX_MAJORITY_EN` and `BAUD_RATE`=1_000_000, a 1-cycle inverted glitch at the centre of bit 3 of 0xa5 → 0xa5 received intact.
- Assert `rst` for 1 cycle during bit 4 of a frame → valid=0 and count=0 next cycle. A following frame 0x3e is received as 0x3e.
